// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths, operation encoding and parameter checks for the sync FIFO
package fifo_pkg;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Pointer width: addresses 0..depth-1.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // True when depth is a power of two and at least 2.
  function automatic bit is_pow2(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  // Full legality check for the FIFO parameter set.
  function automatic bit params_ok(input int data_w, input int depth,
                                   input int af_lvl, input int ae_lvl);
    bit ok;
    ok = is_pow2(depth);
    ok = ok && (data_w >= 1) && (data_w <= 64);
    ok = ok && (af_lvl >= 1) && (af_lvl <= depth - 1);
    ok = ok && (ae_lvl >= 1) && (ae_lvl <= depth - 1);
    return ok;
  endfunction

  // Accepted operations in one cycle, encoded as {write, read}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_W storage, one sync write port and one registered read port
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write and read on the same edge; a read of the slot being written returns the old word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - single-clock parameterised FIFO with occupancy flags and error pulses
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         data,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         data_o,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   fifo_cnt,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LVL);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_LVL);

  if (!params_ok(DATA_W, DEPTH, AF_LVL, AE_LVL)) begin : g_bad_params
    $error("param_sync_fifo: illegal DATA_W/DEPTH/AF_LVL/AE_LVL combination");
  end

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  // Set by reset so data_o reads 0 until the first accepted read loads the read register.
  logic          dzero_q, dzero_d;

  logic          wr_acc;
  logic          rd_acc;
  fifo_op_e      op;
  logic [DATA_W-1:0] mem_rdata;

  // Flags come straight from the registered count so they line up with fifo_cnt.
  always_comb begin
    full         = (cnt_q == CNT_FULL);
    empty        = (cnt_q == '0);
    almost_full  = (cnt_q >= CNT_AF);
    almost_empty = (cnt_q <= CNT_AE);
  end

  // Accept decisions: a full FIFO still takes a write when a read frees a slot this cycle.
  always_comb begin
    rd_acc = rd_en && !empty;
    wr_acc = wr_en && (!full || rd_en);
    op     = fifo_op_e'({wr_acc, rd_acc});
  end

  // Next-state for pointers, count, error pulses and the post-reset zero mask.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    dzero_d = dzero_q;
    ovf_d   = wr_en && !wr_acc;
    unf_d   = rd_en && !rd_acc;
    if (wr_acc) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (rd_acc) begin
      rptr_d  = rptr_q + AW'(1);
      dzero_d = 1'b0;
    end
    case (op)
      OP_WR:   cnt_d = cnt_q + CW'(1);
      OP_RD:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state register; reset wins over any request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      dzero_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      dzero_q <= dzero_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc && !rst),
    .waddr_i (wptr_q),
    .wdata_i (data),
    .re_i    (rd_acc && !rst),
    .raddr_i (rptr_q),
    .rdata_o (mem_rdata)
  );

  assign data_o    = dzero_q ? '0 : mem_rdata;
  assign fifo_cnt  = cnt_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - self-checking bench for param_sync_fifo
module tb_param_sync_fifo;
  import fifo_pkg::*;

  localparam int A_DW = 8;
  localparam int A_D  = 16;
  localparam int A_AF = A_D - 2;
  localparam int A_AE = 2;
  localparam int B_DW = 12;
  localparam int B_D  = 4;
  localparam int B_AF = B_D - 2;
  localparam int B_AE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic                    a_rst = 1'b0, a_wr = 1'b0, a_rd = 1'b0;
  logic [A_DW-1:0]         a_d = '0, a_q;
  logic                    a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [cnt_w(A_D)-1:0]   a_cnt;

  logic                    b_rst = 1'b0, b_wr = 1'b0, b_rd = 1'b0;
  logic [B_DW-1:0]         b_d = '0, b_q;
  logic                    b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [cnt_w(B_D)-1:0]   b_cnt;

  param_sync_fifo #(.DATA_W(A_DW), .DEPTH(A_D), .AF_LVL(A_AF), .AE_LVL(A_AE)) dut_a (
    .clk(clk), .rst(a_rst), .wr_en(a_wr), .data(a_d), .rd_en(a_rd), .data_o(a_q),
    .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
    .fifo_cnt(a_cnt), .overflow(a_ovf), .underflow(a_unf)
  );

  param_sync_fifo #(.DATA_W(B_DW), .DEPTH(B_D), .AF_LVL(B_AF), .AE_LVL(B_AE)) dut_b (
    .clk(clk), .rst(b_rst), .wr_en(b_wr), .data(b_d), .rd_en(b_rd), .data_o(b_q),
    .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
    .fifo_cnt(b_cnt), .overflow(b_ovf), .underflow(b_unf)
  );

  // Reference models: a queue of stored words plus the last word read out.
  logic [63:0] qa[$];
  logic [63:0] qb[$];
  logic [63:0] ea_data = '0, eb_data = '0;
  bit ea_ovf = 0, ea_unf = 0, eb_ovf = 0, eb_unf = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance a FIFO model by one clock given the requests seen on that edge.
  task automatic model_step(inout logic [63:0] q[$], input int depth, input bit r,
                            input bit w, input bit rd, input logic [63:0] d,
                            inout logic [63:0] edata, inout bit eovf, inout bit eunf);
    bit rd_ok, wr_ok;
    if (r) begin
      q.delete();
      edata = '0;
      eovf  = 0;
      eunf  = 0;
    end else begin
      rd_ok = rd && (q.size() > 0);
      wr_ok = w && ((q.size() < depth) || rd);
      if (rd_ok) edata = q.pop_front();
      if (wr_ok) q.push_back(d);
      eovf = w && !wr_ok;
      eunf = rd && !rd_ok;
    end
  endtask

  task automatic step_a(input bit r, input bit w, input bit rd, input logic [A_DW-1:0] d);
    a_rst = r; a_wr = w; a_rd = rd; a_d = d;
    @(posedge clk); #1;
    model_step(qa, A_D, r, w, rd, 64'(d), ea_data, ea_ovf, ea_unf);
    chk("a.cnt",   64'(a_cnt),   64'(qa.size()));
    chk("a.full",  64'(a_full),  64'(qa.size() == A_D));
    chk("a.empty", 64'(a_empty), 64'(qa.size() == 0));
    chk("a.af",    64'(a_af),    64'(qa.size() >= A_AF));
    chk("a.ae",    64'(a_ae),    64'(qa.size() <= A_AE));
    chk("a.data",  64'(a_q),     ea_data);
    chk("a.ovf",   64'(a_ovf),   64'(ea_ovf));
    chk("a.unf",   64'(a_unf),   64'(ea_unf));
  endtask

  task automatic step_b(input bit r, input bit w, input bit rd, input logic [B_DW-1:0] d);
    b_rst = r; b_wr = w; b_rd = rd; b_d = d;
    @(posedge clk); #1;
    model_step(qb, B_D, r, w, rd, 64'(d), eb_data, eb_ovf, eb_unf);
    chk("b.cnt",   64'(b_cnt),   64'(qb.size()));
    chk("b.full",  64'(b_full),  64'(qb.size() == B_D));
    chk("b.empty", 64'(b_empty), 64'(qb.size() == 0));
    chk("b.af",    64'(b_af),    64'(qb.size() >= B_AF));
    chk("b.ae",    64'(b_ae),    64'(qb.size() <= B_AE));
    chk("b.data",  64'(b_q),     eb_data);
    chk("b.ovf",   64'(b_ovf),   64'(eb_ovf));
    chk("b.unf",   64'(b_unf),   64'(eb_unf));
  endtask

  typedef struct {
    bit         rst;
    bit         wr;
    bit         rd;
    logic [7:0] d;
    int         cnt;
    bit         full;
    bit         empty;
    bit         ovf;
    bit         unf;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[10];
  int   af_first;

  initial begin
    tbl[0] = '{1, 1, 1, 8'hFF, 0, 0, 1, 0, 0, 8'h00};
    tbl[1] = '{0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 8'h00};
    tbl[2] = '{0, 1, 0, 8'h11, 1, 0, 0, 0, 0, 8'h00};
    tbl[3] = '{0, 1, 0, 8'h22, 2, 0, 0, 0, 0, 8'h00};
    tbl[4] = '{0, 1, 1, 8'h33, 2, 0, 0, 0, 0, 8'h11};
    tbl[5] = '{0, 0, 1, 8'h00, 1, 0, 0, 0, 0, 8'h22};
    tbl[6] = '{0, 0, 1, 8'h00, 0, 0, 1, 0, 0, 8'h33};
    tbl[7] = '{0, 1, 1, 8'hA5, 1, 0, 0, 0, 1, 8'h33};
    tbl[8] = '{0, 0, 1, 8'h00, 0, 0, 1, 0, 0, 8'hA5};
    tbl[9] = '{0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'hA5};

    for (int i = 0; i < 10; i++) begin
      a_rst = tbl[i].rst; a_wr = tbl[i].wr; a_rd = tbl[i].rd; a_d = tbl[i].d;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d.cnt", i),   64'(a_cnt),   64'(tbl[i].cnt));
      chk($sformatf("tbl%0d.full", i),  64'(a_full),  64'(tbl[i].full));
      chk($sformatf("tbl%0d.empty", i), 64'(a_empty), 64'(tbl[i].empty));
      chk($sformatf("tbl%0d.ovf", i),   64'(a_ovf),   64'(tbl[i].ovf));
      chk($sformatf("tbl%0d.unf", i),   64'(a_unf),   64'(tbl[i].unf));
      chk($sformatf("tbl%0d.data", i),  64'(a_q),     64'(tbl[i].dout));
    end

    // Fill to full, watching where almost_full first rises.
    step_a(1, 0, 0, 8'h00);
    af_first = -1;
    for (int i = 0; i < 16; i++) begin
      step_a(0, 1, 0, 8'(i + 1));
      if (a_af && af_first < 0) af_first = int'(a_cnt);
    end
    chk("fill.af_first", 64'(af_first), 64'(14));
    chk("fill.full", 64'(a_full), 64'(1));
    chk("fill.cnt", 64'(a_cnt), 64'(16));

    // Rejected write when full, then drain in order.
    step_a(0, 1, 0, 8'hEE);
    chk("ovf.pulse", 64'(a_ovf), 64'(1));
    chk("ovf.cnt", 64'(a_cnt), 64'(16));
    step_a(0, 0, 0, 8'h00);
    chk("ovf.clear", 64'(a_ovf), 64'(0));
    for (int i = 0; i < 16; i++) begin
      step_a(0, 0, 1, 8'h00);
      chk($sformatf("drain%0d", i), 64'(a_q), 64'(i + 1));
    end
    chk("drain.empty", 64'(a_empty), 64'(1));

    // Read+write on empty: read rejected, write kept.
    step_a(0, 1, 1, 8'hA5);
    chk("uf.pulse", 64'(a_unf), 64'(1));
    chk("uf.cnt", 64'(a_cnt), 64'(1));
    step_a(0, 0, 1, 8'h00);
    chk("uf.data", 64'(a_q), 64'(8'hA5));

    // Read+write on full: write lands in the freed slot.
    for (int i = 0; i < 16; i++) step_a(0, 1, 0, 8'(i + 1));
    step_a(0, 1, 1, 8'h77);
    chk("rwfull.data", 64'(a_q), 64'(8'h01));
    chk("rwfull.cnt", 64'(a_cnt), 64'(16));
    for (int i = 0; i < 15; i++) step_a(0, 0, 1, 8'h00);
    step_a(0, 0, 1, 8'h00);
    chk("rwfull.last", 64'(a_q), 64'(8'h77));
    step_a(0, 0, 0, 8'h00);

    // Random traffic on a small FIFO with a reset mid-stream.
    step_b(1, 0, 0, 12'h000);
    for (int i = 0; i < 40; i++) begin
      if (i == 25) begin
        step_b(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom));
        chk("rst.cnt", 64'(b_cnt), 64'(0));
        chk("rst.empty", 64'(b_empty), 64'(1));
        chk("rst.data", 64'(b_q), 64'(0));
      end else begin
        step_b(0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5, 12'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
